// File: rtl/cache_ctrl_fsm_pkg.sv
// Shared cache-controller definitions: FSM state encoding and default line size.
package cache_pkg;

  // Miss-handling states; 2-bit encoding is fixed so datapath glue can decode it.
  typedef enum logic [1:0] {
    IDLE        = 2'b00,
    WRITEBACK   = 2'b01,
    ALLOCATE    = 2'b10,
    REFILL_DONE = 2'b11
  } t_cache_state;

  // Default words per line, shared with the cache datapath and main_fsm glue.
  localparam int unsigned CACHE_BLOCK_WORDS = 8;

endpackage

// File: rtl/cache_ctrl_fsm_if.sv
// Bundle of the access/memory signals between main_fsm, the cache datapath,
// memory and the miss controller.
//
// Handshake: a memory beat transfers in every cycle where o_mem_wr_req or
// o_mem_rd_req is high and i_mem_ready is 1. The request stays high for the
// whole burst; i_mem_ready=0 stalls the beat with all outputs held. i_start is
// held by main_fsm until o_stall falls in a cycle where it is high.
interface cache_ctrl_fsm_if #(
  parameter int unsigned WORD_CNT_W = 3
);
  logic                    i_start;
  logic                    i_write_access;
  logic                    i_hit;
  logic                    i_dirty;
  logic                    i_mem_ready;
  logic                    o_stall;
  logic                    o_mem_rd_req;
  logic                    o_mem_wr_req;
  logic [WORD_CNT_W-1:0]   o_word_idx;
  logic                    o_line_fill_we;
  logic                    o_tag_write;
  logic                    o_data_we;
  logic                    o_dirty_set;
  cache_pkg::t_cache_state dbg_state;

  // Controller side.
  modport slave (
    input  i_start, i_write_access, i_hit, i_dirty, i_mem_ready,
    output o_stall, o_mem_rd_req, o_mem_wr_req, o_word_idx,
    output o_line_fill_we, o_tag_write, o_data_we, o_dirty_set, dbg_state
  );

  // Requester / memory side.
  modport master (
    output i_start, i_write_access, i_hit, i_dirty, i_mem_ready,
    input  o_stall, o_mem_rd_req, o_mem_wr_req, o_word_idx,
    input  o_line_fill_we, o_tag_write, o_data_we, o_dirty_set, dbg_state
  );
endinterface

// File: rtl/cache_ctrl_fsm_beat_counter.sv
// Beat index counter for write-back and refill bursts; wraps naturally at the
// power-of-two line size.
module cache_beat_counter #(
  parameter int unsigned WORD_CNT_W = 3
) (
  input  logic                  clk,
  input  logic                  arstn,
  input  logic                  clear,
  input  logic                  enable,
  output logic [WORD_CNT_W-1:0] o_cnt,
  output logic                  o_last
);
  logic [WORD_CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear wins over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + WORD_CNT_W'(1);
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!arstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_cnt  = cnt_q;
  assign o_last = (cnt_q == {WORD_CNT_W{1'b1}});
endmodule

// File: rtl/cache_ctrl_fsm.sv
// Miss-handling controller for one direct-mapped cache: zero-latency hits,
// optional dirty-line writeback, then a one-word-per-beat refill.
module cache_ctrl_fsm
  import cache_pkg::*;
#(
  parameter int unsigned BLOCK_WORDS = CACHE_BLOCK_WORDS,
  parameter bit          WRITE_BACK  = 1'b1
) (
  input  logic                    clk,
  input  logic                    arstn,
  cache_ctrl_fsm_if.slave         bus
);
  localparam int unsigned WORD_CNT_W = $clog2(BLOCK_WORDS);

  localparam logic [1:0] ST_IDLE        = IDLE;
  localparam logic [1:0] ST_WRITEBACK   = WRITEBACK;
  localparam logic [1:0] ST_ALLOCATE    = ALLOCATE;
  localparam logic [1:0] ST_REFILL_DONE = REFILL_DONE;

  logic [1:0]            state_q, state_d;
  logic                  cnt_clr, cnt_en, cnt_last;
  logic [WORD_CNT_W-1:0] cnt;

  cache_beat_counter #(.WORD_CNT_W(WORD_CNT_W)) u_beat_cnt (
    .clk    (clk),
    .arstn  (arstn),
    .clear  (cnt_clr),
    .enable (cnt_en),
    .o_cnt  (cnt),
    .o_last (cnt_last)
  );

  // Next-state and output decode from state plus same-cycle inputs.
  always_comb begin
    state_d            = state_q;
    cnt_clr            = 1'b0;
    cnt_en             = 1'b0;
    bus.o_stall        = 1'b0;
    bus.o_mem_rd_req   = 1'b0;
    bus.o_mem_wr_req   = 1'b0;
    bus.o_word_idx     = '0;
    bus.o_line_fill_we = 1'b0;
    bus.o_tag_write    = 1'b0;
    bus.o_data_we      = 1'b0;
    bus.o_dirty_set    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_start) begin
          if (bus.i_hit) begin
            // Store hit updates the line and marks it dirty in the same cycle.
            bus.o_data_we   = WRITE_BACK && bus.i_write_access;
            bus.o_dirty_set = WRITE_BACK && bus.i_write_access;
          end else begin
            bus.o_stall = 1'b1;
            cnt_clr     = 1'b1;
            state_d     = (WRITE_BACK && bus.i_dirty) ? ST_WRITEBACK : ST_ALLOCATE;
          end
        end
      end
      ST_WRITEBACK: begin
        bus.o_stall      = 1'b1;
        bus.o_mem_wr_req = 1'b1;
        bus.o_word_idx   = cnt;
        cnt_en           = bus.i_mem_ready;
        if (bus.i_mem_ready && cnt_last) begin
          state_d = ST_ALLOCATE;
        end
      end
      ST_ALLOCATE: begin
        bus.o_stall        = 1'b1;
        bus.o_mem_rd_req   = 1'b1;
        bus.o_word_idx     = cnt;
        bus.o_line_fill_we = bus.i_mem_ready;
        cnt_en             = bus.i_mem_ready;
        if (bus.i_mem_ready && cnt_last) begin
          state_d = ST_REFILL_DONE;
        end
      end
      ST_REFILL_DONE: begin
        // Tag/valid written here; the held request re-looks up and hits in IDLE.
        bus.o_stall     = 1'b1;
        bus.o_tag_write = 1'b1;
        state_d         = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register; reset abandons any in-flight burst.
  always_ff @(posedge clk) begin
    if (!arstn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign bus.dbg_state = t_cache_state'(state_q);
endmodule
